// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the register-index type used by the
// MEM/WB stage, the register file and the decode-side scoreboard.
package pipe_pkg;

    localparam int DATA_W    = 64;
    localparam int NREG      = 32;
    localparam int ZERO_REG  = 31;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-writer scoreboard: a saturating 2-bit counter per
// architectural register, the read-port busy flags and a sticky overflow flag.
module wb_scoreboard #(
    parameter int NREG     = pipe_pkg::NREG,
    parameter int ZERO_REG = pipe_pkg::ZERO_REG
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               rsv_en,
    input  pipe_pkg::reg_idx_t rsv_reg,
    input  logic               wb_regwrite,
    input  pipe_pkg::reg_idx_t wb_reg_dest,
    input  pipe_pkg::reg_idx_t rd_addr_a,
    input  pipe_pkg::reg_idx_t rd_addr_b,
    output logic               rd_busy_a,
    output logic               rd_busy_b,
    output logic               rsv_ovf
);

    import pipe_pkg::*;

    localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

    logic [1:0] cnt      [NREG];
    logic [1:0] cnt_next [NREG];
    logic       ovf_set;
    logic [1:0] cnt_a;
    logic [1:0] cnt_b;
    logic       hit_a;
    logic       hit_b;

    // A port is busy while writers remain outstanding after any writeback
    // landing this very cycle (that one is already covered by the bypass).
    function automatic logic busy_from(input logic [1:0] c, input logic hit);
        return (c > 2'd1) || ((c == 2'd1) && !hit);
    endfunction

    // Next counter values: a reservation and a writeback on the same register
    // cancel out; a reservation on a full counter saturates and flags overflow.
    always_comb begin
        ovf_set = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            logic inc;
            logic dec;
            inc = rsv_en && (rsv_reg == reg_idx_t'(i)) && (i != ZERO_REG);
            dec = wb_regwrite && (wb_reg_dest == reg_idx_t'(i)) && (cnt[i] != 2'd0);
            cnt_next[i] = cnt[i];
            if (inc && !dec) begin
                if (cnt[i] == 2'd3) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + 2'd1;
                end
            end else if (dec && !inc) begin
                cnt_next[i] = cnt[i] - 2'd1;
            end
        end
    end

    // Counter array and sticky overflow flag; reset drops every reservation.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= 2'd0;
            end
            rsv_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (ovf_set) begin
                rsv_ovf <= 1'b1;
            end
        end
    end

    // Look up the read-port counters; the zero register is never busy.
    always_comb begin
        cnt_a = 2'd0;
        cnt_b = 2'd0;
        if ((rd_addr_a != ZERO_IDX) && (int'(rd_addr_a) < NREG)) begin
            cnt_a = cnt[rd_addr_a];
        end
        if ((rd_addr_b != ZERO_IDX) && (int'(rd_addr_b) < NREG)) begin
            cnt_b = cnt[rd_addr_b];
        end
        hit_a     = wb_regwrite && (wb_reg_dest == rd_addr_a);
        hit_b     = wb_regwrite && (wb_reg_dest == rd_addr_b);
        rd_busy_a = busy_from(cnt_a, hit_a);
        rd_busy_b = busy_from(cnt_b, hit_b);
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: two combinational read ports with
// write-through bypass, a hardwired zero register, and a pending-write
// scoreboard so decode can tell when an operand is still in flight.
module wb_regfile #(
    parameter int DATA_W   = pipe_pkg::DATA_W,
    parameter int NREG     = pipe_pkg::NREG,
    parameter int ZERO_REG = pipe_pkg::ZERO_REG
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [DATA_W-1:0]  WB_MEM_DATA,
    input  logic [DATA_W-1:0]  WB_ALU_VAL,
    input  pipe_pkg::reg_idx_t WB_REG_DEST,
    input  logic               WB_REGWRITE,
    input  logic               WB_MEM2REG,
    input  pipe_pkg::reg_idx_t RD_ADDR_A,
    input  pipe_pkg::reg_idx_t RD_ADDR_B,
    output logic [DATA_W-1:0]  RD_DATA_A,
    output logic [DATA_W-1:0]  RD_DATA_B,
    output logic               RD_BUSY_A,
    output logic               RD_BUSY_B,
    input  logic               RSV_EN,
    input  pipe_pkg::reg_idx_t RSV_REG,
    output logic [DATA_W-1:0]  WB_DATA,
    output logic               RSV_OVF
);

    import pipe_pkg::*;

    localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic              write_en;

    // Writeback value selection and the qualified write strobe.
    always_comb begin
        WB_DATA  = WB_MEM2REG ? WB_MEM_DATA : WB_ALU_VAL;
        write_en = WB_REGWRITE && (WB_REG_DEST != ZERO_IDX) && (int'(WB_REG_DEST) < NREG);
    end

    // Register array; reset clears every entry so no writeback survives it.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[WB_REG_DEST] <= WB_DATA;
        end
    end

    // Read ports: zero register first, then same-cycle bypass, then the array.
    always_comb begin
        RD_DATA_A = '0;
        RD_DATA_B = '0;
        if (RD_ADDR_A != ZERO_IDX) begin
            if (WB_REGWRITE && (WB_REG_DEST == RD_ADDR_A)) begin
                RD_DATA_A = WB_DATA;
            end else if (int'(RD_ADDR_A) < NREG) begin
                RD_DATA_A = regs[RD_ADDR_A];
            end
        end
        if (RD_ADDR_B != ZERO_IDX) begin
            if (WB_REGWRITE && (WB_REG_DEST == RD_ADDR_B)) begin
                RD_DATA_B = WB_DATA;
            end else if (int'(RD_ADDR_B) < NREG) begin
                RD_DATA_B = regs[RD_ADDR_B];
            end
        end
    end

    wb_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .CLK         (CLK),
        .RESET       (RESET),
        .rsv_en      (RSV_EN),
        .rsv_reg     (RSV_REG),
        .wb_regwrite (WB_REGWRITE),
        .wb_reg_dest (WB_REG_DEST),
        .rd_addr_a   (RD_ADDR_A),
        .rd_addr_b   (RD_ADDR_B),
        .rd_busy_a   (RD_BUSY_A),
        .rd_busy_b   (RD_BUSY_B),
        .rsv_ovf     (RSV_OVF)
    );

endmodule
